opp_matrix_seq: RTL and testbench

//  Sequencer that sits around the combinational row negator opp_M (m_1 -> m_out, ovf).

---
 rtl/opp_matrix_seq_if.sv | 28 ++
 rtl/opp_matrix_seq.sv | 95 +++++++++
 tb/tb_opp_matrix_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/opp_matrix_seq_if.sv
// Bus between the opposite-matrix sequencer and its client/row negator.
// The master side issues start/m_in and returns the negated row; the slave is the sequencer.
interface opp_matrix_seq_if #(
  parameter int N = 5,
  parameter int W = 8
);
  logic               start;
  logic [N*N*W-1:0]   m_in;
  logic [N*W-1:0]     row_out;
  logic [N*W-1:0]     row_in;
  logic               ovf_in;
  logic               row_vld;
  logic               busy;
  logic               done;
  logic [N*N*W-1:0]   m_out;
  logic               ovf;
  logic [N-1:0]       ovf_row;

  modport master (
    output start, m_in, row_in, ovf_in,
    input  row_out, row_vld, busy, done, m_out, ovf, ovf_row
  );

  modport slave (
    input  start, m_in, row_in, ovf_in,
    output row_out, row_vld, busy, done, m_out, ovf, ovf_row
  );
endinterface

// File: rtl/opp_matrix_seq.sv
// Opposite-matrix sequencer: latches an N x N matrix, streams one row per clock
// through an external row negator and gathers the negated rows plus overflow flags.
module opp_matrix_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst,
  opp_matrix_seq_if.slave  bus
);

  localparam int RW = N * W;
  localparam int MW = N * N * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [MW-1:0]   buf_q, buf_d;
  logic [MW-1:0]   mout_q, mout_d;
  logic            ovf_q, ovf_d;
  logic [N-1:0]    ovfr_q, ovfr_d;

  // Row 0 sits in the MSBs, so row r starts (N-1-r) rows up from bit 0.
  function automatic logic [RW-1:0] get_row(input logic [MW-1:0] m, input logic [IW-1:0] r);
    get_row = m[(N - 1 - int'(r)) * RW +: RW];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      mout_q  <= '0;
      ovf_q   <= 1'b0;
      ovfr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      mout_q  <= mout_d;
      ovf_q   <= ovf_d;
      ovfr_q  <= ovfr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    mout_d  = mout_q;
    ovf_d   = ovf_q;
    ovfr_d  = ovfr_q;
    case (state_q)
      IDLE, DONE: begin
        // A new start clears the previous result; without one, results hold.
        if (bus.start) begin
          buf_d   = bus.m_in;
          idx_d   = '0;
          mout_d  = '0;
          ovf_d   = 1'b0;
          ovfr_d  = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        mout_d[(N - 1 - int'(idx_q)) * RW +: RW] = bus.row_in;
        ovfr_d[idx_q] = bus.ovf_in;
        ovf_d         = ovf_q | bus.ovf_in;
        if (idx_q == IW'(N - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.row_vld = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.row_out = (state_q == RUN) ? get_row(buf_q, idx_q) : '0;
  assign bus.m_out   = mout_q;
  assign bus.ovf     = ovf_q;
  assign bus.ovf_row = ovfr_q;

endmodule

// File: tb/tb_opp_matrix_seq.sv
// Bench for opp_matrix_seq with a behavioural row negator standing in for opp_M.
module tb_opp_matrix_seq;

  localparam int N = 5;
  localparam int W = 8;

  logic clk;
  logic rst;

  opp_matrix_seq_if #(.N(N), .W(W)) bus ();

  opp_matrix_seq #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row negator: element-wise two's complement negation, ovf when an element is -128.
  always_comb begin
    logic [W-1:0] el;
    el         = '0;
    bus.row_in = '0;
    bus.ovf_in = 1'b0;
    for (int e = 0; e < N; e++) begin
      el = bus.row_out[e*W +: W];
      bus.row_in[e*W +: W] = -el;
      if (el == 8'h80) bus.ovf_in = 1'b1;
    end
  end

  typedef struct {
    logic [199:0] m;
    logic [199:0] exp_m;
    logic         exp_ovf;
    logic [4:0]   exp_ovfr;
  } vec_t;

  vec_t tv [5];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [199:0] m);
    @(negedge clk);
    bus.m_in  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges (sampled #1 after each) until done, bounded.
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.done && k < 20);
  endtask

  task automatic run_vec(input int i);
    int k;
    string s;
    s = $sformatf("v%0d", i);
    launch(tv[i].m);
    chk({s, " busy"}, 200'(bus.busy), 200'(1));
    chk({s, " row_vld"}, 200'(bus.row_vld), 200'(1));
    chk({s, " row_out0"}, 200'(bus.row_out), 200'(tv[i].m[199:160]));
    wait_done(k);
    chk({s, " latency"}, 200'(k), 200'(5));
    chk({s, " m_out"}, bus.m_out, tv[i].exp_m);
    chk({s, " ovf"}, 200'(bus.ovf), 200'(tv[i].exp_ovf));
    chk({s, " ovf_row"}, 200'(bus.ovf_row), 200'(tv[i].exp_ovfr));
    chk({s, " done_busy"}, 200'(bus.busy), 200'(0));
    @(posedge clk);
    #1;
    chk({s, " done_pulse"}, 200'(bus.done), 200'(0));
    chk({s, " row_out_idle"}, 200'(bus.row_out), 200'(0));
    @(posedge clk);
    #1;
    chk({s, " m_out_hold"}, bus.m_out, tv[i].exp_m);
    chk({s, " ovf_row_hold"}, 200'(bus.ovf_row), 200'(tv[i].exp_ovfr));
  endtask

  initial begin
    int k;
    int ndone;
    n_cmp  = 0;
    n_fail = 0;

    tv[0] = '{m: {5{40'h0103020500}}, exp_m: {5{40'hFFFDFEFB00}}, exp_ovf: 1'b0, exp_ovfr: 5'b00000};
    tv[1] = '{m: {5{40'hFFFDFEFB00}}, exp_m: {5{40'h0103020500}}, exp_ovf: 1'b0, exp_ovfr: 5'b00000};
    tv[2] = '{m: {80'h0, 40'h8000000000, 80'h0},
              exp_m: {80'h0, 40'h8000000000, 80'h0}, exp_ovf: 1'b1, exp_ovfr: 5'b00100};
    tv[3] = '{m: {40'h7F8001FF10, 40'h0A0B0C0D0E, 40'h0, 40'h0, 40'h8080808080},
              exp_m: {40'h8180FF01F0, 40'hF6F5F4F3F2, 40'h0, 40'h0, 40'h8080808080},
              exp_ovf: 1'b1, exp_ovfr: 5'b10001};
    tv[4] = '{m: {40'h6440C0E7F6, 40'h0, 40'h0, 40'h0, 40'h0102030405},
              exp_m: {40'h9CC040190A, 40'h0, 40'h0, 40'h0, 40'hFFFEFDFCFB},
              exp_ovf: 1'b0, exp_ovfr: 5'b00000};

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.m_in  = '0;
    #12;
    chk("rst busy", 200'(bus.busy), 200'(0));
    chk("rst done", 200'(bus.done), 200'(0));
    chk("rst row_vld", 200'(bus.row_vld), 200'(0));
    chk("rst row_out", 200'(bus.row_out), 200'(0));
    chk("rst m_out", bus.m_out, 200'(0));
    chk("rst ovf", 200'(bus.ovf), 200'(0));
    chk("rst ovf_row", 200'(bus.ovf_row), 200'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Start pulsed at E2 with a different matrix must be ignored.
    launch(tv[0].m);
    @(posedge clk);
    #1;
    bus.m_in  = tv[1].m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(k);
    chk("busy_start latency", 200'(k), 200'(3));
    chk("busy_start m_out", bus.m_out, tv[0].exp_m);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("busy_start extra_done", 200'(ndone), 200'(0));
    chk("busy_start m_out_hold", bus.m_out, tv[0].exp_m);

    // Asynchronous reset between E3 and E4.
    launch(tv[3].m);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort busy", 200'(bus.busy), 200'(0));
    chk("abort row_vld", 200'(bus.row_vld), 200'(0));
    chk("abort row_out", 200'(bus.row_out), 200'(0));
    chk("abort m_out", bus.m_out, 200'(0));
    chk("abort ovf", 200'(bus.ovf), 200'(0));
    chk("abort ovf_row", 200'(bus.ovf_row), 200'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort no_done", 200'(ndone), 200'(0));
    run_vec(2);

    // Back-to-back: start held in the DONE cycle.
    launch(tv[0].m);
    wait_done(k);
    chk("b2b first latency", 200'(k), 200'(5));
    chk("b2b first m_out", bus.m_out, tv[0].exp_m);
    bus.m_in  = tv[2].m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b rerun busy", 200'(bus.busy), 200'(1));
    chk("b2b cleared m_out", bus.m_out, 200'(0));
    wait_done(k);
    chk("b2b spacing", 200'(k + 1), 200'(6));
    chk("b2b second m_out", bus.m_out, tv[2].exp_m);
    chk("b2b second ovf", 200'(bus.ovf), 200'(1));
    chk("b2b second ovf_row", 200'(bus.ovf_row), 200'(5'b00100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
